cmult_pipe: RTL and testbench
=============================

// Module: cmult_pipe
// PURPOSE
//  Pipelined, parametrised complex multiplier for the radix-2^2 FFT twiddle stage.
//  Computes m = a*b, or m = a*conj(b), with round-half-up scaling to a programmable output width.
//  Has a valid/ready stream handshake with full backpressure.
//  Sits between each butterfly pair and the next SDF stage; a ROM supplies the twiddle b.
// PARAMETERS
//  IN_W   16  width of signed data a_re/a_im
//  TW_W   16  width of signed twiddle b_re/b_im
//  OUT_W  16  width of signed outputs m_re/m_im
//  SHIFT  15  arithmetic right shift applied after add/sub (twiddle fraction bits); 0 allowed
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      reset, asynchronous, active-low
//  in_valid   in   1      input beat valid
//  in_ready   out  1      block can accept a beat this cycle
//  conj       in   1      1: multiply by conj(b); sampled with the beat
//  a_re,a_im  in   IN_W   signed data operand
//  b_re,b_im  in   TW_W   signed twiddle operand
//  out_valid  out  1      result valid
//  out_ready  in   1      downstream accepts result
//  m_re,m_im  out  OUT_W  signed scaled result
//  ovf        out  1      sticky overflow flag (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: all pipeline valid bits, out_valid, m_re, m_im and ovf are 0. in_ready is 1 after reset.
//  - Pipeline: 3 register stages.
//      S1 registers the operands and conj.
//      S2 registers the four products arbr, arbi, aibr, aibi (IN_W+TW_W bits each).
//      S3 registers the rounded and scaled outputs.
//  - Latency: a beat accepted at edge N appears on m_* with out_valid=1 after edge N+3 when there is no stall.
//  - Advance enable: en = !out_valid | out_ready.
//      All stages (data and valid bits) load only when en=1. in_ready = en (combinational).
//      A beat is accepted when in_valid & in_ready.
//  - Bubbles travel as valid=0 and are not squeezed out.
//  - Holding: m_*/out_valid stay stable while out_valid & !out_ready.
//  - Throughput: 1 beat per cycle when out_ready is held at 1.
//  - Arithmetic, no internal overflow:
//      s_re = arbr - aibi (conj=0) | arbr + aibi (conj=1)
//      s_im = arbi + aibr (conj=0) | aibr - arbi (conj=1)
//      s_* is IN_W+TW_W+1 bits, sign-extended.
//  - Rounding: r = (s + (SHIFT>0 ? 1<<(SHIFT-1) : 0)) >>> SHIFT, computed in full width (round half up).
//  - Narrowing from r to OUT_W bits follows CONFIGURATION.
//  - Reset mid-operation: all in-flight beats are discarded; nothing is emitted after rst_n rises until new input arrives.
//  - ovf clears only on reset.
// CONFIGURATION
//  Macro CMULT_SAT_EN.
//  - Defined: r is clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
//      ovf is set on the S3 load of any valid beat where either component clamped.
//  - Undefined: the low OUT_W bits of r are taken (wrap). ovf is tied to 0 and no clamp logic is built.
// STRUCTURE
//  - Shared package fft_pkg:
//      cplx_t struct template widths;
//      localparams PROD_W = IN_W+TW_W and SUM_W = PROD_W+1;
//      function round_shift();
//      function sat_narrow() (used only under CMULT_SAT_EN).
//  - One sub-module, cmult_round_sat: combinational round, shift and narrow of one component.
//      Instantiated twice, for re and im.
//  - The top level holds the pipeline registers and the handshake.
// TESTING (IN_W=TW_W=OUT_W=16, SHIFT=15)
//  1. Basic: a=(0x4000,0), b=(0x4000,0), conj=0 -> m=(0x2000,0x0000) exactly 3 cycles after acceptance.
//  2. Conj: a=(0,0x4000), b=(0,0x4000).
//       conj=0 -> m=(0xE000,0).
//       Same beat with conj=1 -> m=(0x2000,0).
//  3. Rounding: a=(1,0), b=(0x4000,0) -> m_re=1; a=(-1,0), same b -> m_re=0.
//  4. Overflow: a=(0x8000,0x8000), b=(0x8000,0x8000) -> m_re=0.
//       With CMULT_SAT_EN: m_im=0x7FFF and ovf=1 (sticky across later beats until reset).
//       Without it: m_im=0x0000 and ovf=0.
//  5. Backpressure: stream 8 random beats with in_valid=1.
//       Hold out_ready=0 for 5 cycles mid-stream -> in_ready drops, m_* stays stable, no beat is lost or duplicated.
//       Output order and values match the golden model.
//  6. Reset: pulse rst_n low with 3 beats in flight -> out_valid=0 and ovf=0 immediately, and no stale beat after release.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared FFT datapath types and arithmetic helpers for the twiddle multiplier.
// Helpers work on a fixed 64-bit signed calculation width; callers sign-extend into it.
package fft_pkg;

    localparam int DEF_IN_W  = 16;
    localparam int DEF_TW_W  = 16;
    localparam int DEF_OUT_W = 16;
    localparam int DEF_SHIFT = 15;

    localparam int PROD_W = DEF_IN_W + DEF_TW_W;
    localparam int SUM_W  = PROD_W + 1;
    localparam int CALC_W = 64;

    typedef struct packed {
        logic signed [DEF_IN_W-1:0] re;
        logic signed [DEF_IN_W-1:0] im;
    } cplx_t;

    // Round half up: add half an LSB of the result, then arithmetic shift.
    function automatic logic signed [CALC_W-1:0] round_shift(
        input logic signed [CALC_W-1:0] s,
        input int                       shift
    );
        logic signed [CALC_W-1:0] bias;
        bias = '0;
        if (shift > 0) begin
            bias = 64'sd1 <<< (shift - 1);
        end
        return (s + bias) >>> shift;
    endfunction

    function automatic logic signed [CALC_W-1:0] sat_hi(input int out_w);
        return (64'sd1 <<< (out_w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [CALC_W-1:0] sat_narrow(
        input logic signed [CALC_W-1:0] r,
        input int                       out_w
    );
        logic signed [CALC_W-1:0] hi;
        logic signed [CALC_W-1:0] lo;
        hi = sat_hi(out_w);
        lo = -hi - 64'sd1;
        if (r > hi) begin
            return hi;
        end
        if (r < lo) begin
            return lo;
        end
        return r;
    endfunction

    function automatic logic sat_clamped(
        input logic signed [CALC_W-1:0] r,
        input int                       out_w
    );
        logic signed [CALC_W-1:0] hi;
        hi = sat_hi(out_w);
        return (r > hi) || (r < (-hi - 64'sd1));
    endfunction

endpackage

// File: rtl/cmult_round_sat.sv
// Combinational round, shift and narrow of one product-sum component.
// CMULT_SAT_EN selects clamping with a clamp flag; otherwise the result wraps.
module cmult_round_sat
    import fft_pkg::*;
#(
    parameter int S_W   = SUM_W,
    parameter int OUT_W = DEF_OUT_W,
    parameter int SHIFT = DEF_SHIFT
) (
    input  logic signed [S_W-1:0]   s_i,
`ifdef CMULT_SAT_EN
    output logic                    clamp_o,
`endif
    output logic signed [OUT_W-1:0] m_o
);

`ifdef CMULT_SAT_EN
    assign m_o     = OUT_W'(sat_narrow(round_shift(CALC_W'(s_i), SHIFT), OUT_W));
    assign clamp_o = sat_clamped(round_shift(CALC_W'(s_i), SHIFT), OUT_W);
`else
    assign m_o     = OUT_W'(round_shift(CALC_W'(s_i), SHIFT));
`endif

endmodule

// File: rtl/cmult_pipe.sv
// Three-stage pipelined complex multiplier m = a*b or a*conj(b) with valid/ready backpressure.
// Build with CMULT_SAT_EN for saturating outputs and a sticky ovf flag; default wraps, ovf = 0.
module cmult_pipe
    import fft_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int TW_W  = DEF_TW_W,
    parameter int OUT_W = DEF_OUT_W,
    parameter int SHIFT = DEF_SHIFT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    conj,
    input  logic signed [IN_W-1:0]  a_re,
    input  logic signed [IN_W-1:0]  a_im,
    input  logic signed [TW_W-1:0]  b_re,
    input  logic signed [TW_W-1:0]  b_im,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] m_re,
    output logic signed [OUT_W-1:0] m_im,
    output logic                    ovf
);

    localparam int P_W = IN_W + TW_W;
    localparam int S_W = P_W + 1;

    logic en;

    logic                   v1_q, conj1_q;
    logic signed [IN_W-1:0] a_re_q, a_im_q;
    logic signed [TW_W-1:0] b_re_q, b_im_q;

    logic                  v2_q, conj2_q;
    logic signed [P_W-1:0] arbr_q, arbi_q, aibr_q, aibi_q;

    logic signed [S_W-1:0]   s_re_d, s_im_d;
    logic signed [OUT_W-1:0] m_re_d, m_im_d;
    logic                    v3_q;
    logic signed [OUT_W-1:0] m_re_q, m_im_q;

    // The whole pipeline moves in lockstep; a stalled output freezes every stage.
    assign en       = !v3_q || out_ready;
    assign in_ready = en;

    // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q    <= 1'b0;
            conj1_q <= 1'b0;
            a_re_q  <= '0;
            a_im_q  <= '0;
            b_re_q  <= '0;
            b_im_q  <= '0;
        end else if (en) begin
            v1_q    <= in_valid;
            conj1_q <= conj;
            a_re_q  <= a_re;
            a_im_q  <= a_im;
            b_re_q  <= b_re;
            b_im_q  <= b_im;
        end
    end

    // NOTE: data registers are reset alongside the valid bits so the outputs read 0 after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_q    <= 1'b0;
            conj2_q <= 1'b0;
            arbr_q  <= '0;
            arbi_q  <= '0;
            aibr_q  <= '0;
            aibi_q  <= '0;
        end else if (en) begin
            v2_q    <= v1_q;
            conj2_q <= conj1_q;
            arbr_q  <= P_W'(a_re_q) * P_W'(b_re_q);
            arbi_q  <= P_W'(a_re_q) * P_W'(b_im_q);
            aibr_q  <= P_W'(a_im_q) * P_W'(b_re_q);
            aibi_q  <= P_W'(a_im_q) * P_W'(b_im_q);
        end
    end

    // One guard bit above the product width keeps the add/sub exact.
    assign s_re_d = conj2_q ? S_W'(arbr_q) + S_W'(aibi_q) : S_W'(arbr_q) - S_W'(aibi_q);
    assign s_im_d = conj2_q ? S_W'(aibr_q) - S_W'(arbi_q) : S_W'(arbi_q) + S_W'(aibr_q);

`ifdef CMULT_SAT_EN
    logic clamp_re, clamp_im;
`endif

    cmult_round_sat #(
        .S_W   (S_W),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT)
    ) u_round_re (
        .s_i     (s_re_d),
`ifdef CMULT_SAT_EN
        .clamp_o (clamp_re),
`endif
        .m_o     (m_re_d)
    );

    cmult_round_sat #(
        .S_W   (S_W),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT)
    ) u_round_im (
        .s_i     (s_im_d),
`ifdef CMULT_SAT_EN
        .clamp_o (clamp_im),
`endif
        .m_o     (m_im_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v3_q   <= 1'b0;
            m_re_q <= '0;
            m_im_q <= '0;
        end else if (en) begin
            v3_q   <= v2_q;
            m_re_q <= m_re_d;
            m_im_q <= m_im_d;
        end
    end

`ifdef CMULT_SAT_EN
    logic ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (en && v2_q && (clamp_re || clamp_im)) begin
            ovf_q <= 1'b1;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    assign out_valid = v3_q;
    assign m_re      = m_re_q;
    assign m_im      = m_im_q;

endmodule

// File: tb/tb_cmult_pipe.sv
// Directed self-checking bench for cmult_pipe at 16/16/16 bits, SHIFT = 15.
// Works in both the wrapping and the CMULT_SAT_EN builds.
module tb_cmult_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        conj;
    logic [15:0] a_re, a_im, b_re, b_im;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] m_re, m_im;
    logic        ovf;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef CMULT_SAT_EN
    localparam logic [15:0] OVF_IM   = 16'h7FFF;
    localparam logic        OVF_FLAG = 1'b1;
`else
    localparam logic [15:0] OVF_IM   = 16'h0000;
    localparam logic        OVF_FLAG = 1'b0;
`endif

    cmult_pipe #(
        .IN_W  (16),
        .TW_W  (16),
        .OUT_W (16),
        .SHIFT (15)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .conj      (conj),
        .a_re      (a_re),
        .a_im      (a_im),
        .b_re      (b_re),
        .b_im      (b_im),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .m_re      (m_re),
        .m_im      (m_im),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference arithmetic in 64-bit integers, independent of the RTL structure.
    function automatic logic [31:0] model(input logic signed [15:0] ar, input logic signed [15:0] ai,
                                          input logic signed [15:0] br, input logic signed [15:0] bi,
                                          input logic cj);
        longint pr_rr, pr_ri, pr_ir, pr_ii, s_r, s_i, r_r, r_i;
        pr_rr = longint'(ar) * longint'(br);
        pr_ri = longint'(ar) * longint'(bi);
        pr_ir = longint'(ai) * longint'(br);
        pr_ii = longint'(ai) * longint'(bi);
        s_r = cj ? pr_rr + pr_ii : pr_rr - pr_ii;
        s_i = cj ? pr_ir - pr_ri : pr_ri + pr_ir;
        r_r = (s_r + 64'sd16384) >>> 15;
        r_i = (s_i + 64'sd16384) >>> 15;
`ifdef CMULT_SAT_EN
        if (r_r > 32767) r_r = 32767;
        if (r_r < -32768) r_r = -32768;
        if (r_i > 32767) r_i = 32767;
        if (r_i < -32768) r_i = -32768;
`endif
        return {r_r[15:0], r_i[15:0]};
    endfunction

    // Present one beat right after an edge and expect it three edges later, idle before then.
    task automatic send_check(input string tag, input logic [15:0] ar, input logic [15:0] ai,
                              input logic [15:0] br, input logic [15:0] bi, input logic cj,
                              input logic [15:0] exp_re, input logic [15:0] exp_im);
        @(posedge clk);
        #1;
        a_re = ar; a_im = ai; b_re = br; b_im = bi; conj = cj;
        in_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk);
            #1;
            if (i == 1) in_valid = 1'b0;
            if (i < 3) check({tag, " early valid"}, out_valid, 1'b0);
        end
        check({tag, " valid"}, out_valid, 1'b1);
        check({tag, " re"}, m_re, exp_re);
        check({tag, " im"}, m_im, exp_im);
    endtask

    logic [31:0] exp_q[$];
    logic        mon_en = 1'b0;
    int          got_cnt = 0;

    // Output monitor: scoreboard on consumed beats and hold-stability while stalled.
    initial begin
        logic        prev_stall;
        logic [15:0] held_re, held_im;
        logic [31:0] e;
        prev_stall = 1'b0;
        held_re = '0;
        held_im = '0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (prev_stall) begin
                    check("hold valid", out_valid, 1'b1);
                    check("hold re", m_re, held_re);
                    check("hold im", m_im, held_im);
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("extra beat", 1'b1, 1'b0);
                    end else begin
                        e = exp_q.pop_front();
                        check("stream re", m_re, e[31:16]);
                        check("stream im", m_im, e[15:0]);
                        got_cnt++;
                    end
                end
                prev_stall = out_valid && !out_ready;
                held_re = m_re;
                held_im = m_im;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    initial begin
        int stale;
        rst_n = 1'b0;
        in_valid = 1'b0;
        conj = 1'b0;
        out_ready = 1'b1;
        a_re = '0; a_im = '0; b_re = '0; b_im = '0;

        #2;
        check("rst out_valid", out_valid, 1'b0);
        check("rst in_ready", in_ready, 1'b1);
        check("rst m_re", m_re, 16'h0000);
        check("rst m_im", m_im, 16'h0000);
        check("rst ovf", ovf, 1'b0);
        #20;
        rst_n = 1'b1;

        send_check("basic", 16'h4000, 16'h0000, 16'h4000, 16'h0000, 1'b0, 16'h2000, 16'h0000);
        send_check("conj0", 16'h0000, 16'h4000, 16'h0000, 16'h4000, 1'b0, 16'hE000, 16'h0000);
        send_check("conj1", 16'h0000, 16'h4000, 16'h0000, 16'h4000, 1'b1, 16'h2000, 16'h0000);
        send_check("round up", 16'h0001, 16'h0000, 16'h4000, 16'h0000, 1'b0, 16'h0001, 16'h0000);
        send_check("round neg", 16'hFFFF, 16'h0000, 16'h4000, 16'h0000, 1'b0, 16'h0000, 16'h0000);
        check("ovf clear", ovf, 1'b0);
        send_check("overflow", 16'h8000, 16'h8000, 16'h8000, 16'h8000, 1'b0, 16'h0000, OVF_IM);
        check("ovf set", ovf, OVF_FLAG);

        // Backpressure: 8 beats streamed, output stalled for 5 cycles mid-stream.
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        fork
            begin
                for (int k = 0; k < 8; k++) begin
                    logic [31:0] va, vb;
                    logic        acc;
                    int          tries;
                    va = $urandom;
                    vb = $urandom;
                    a_re = va[31:16]; a_im = va[15:0];
                    b_re = vb[31:16]; b_im = vb[15:0];
                    conj = va[3] ^ vb[7];
                    in_valid = 1'b1;
                    tries = 0;
                    acc = 1'b0;
                    while (!acc && tries < 40) begin
                        @(negedge clk);
                        acc = in_ready;
                        @(posedge clk);
                        #1;
                        tries++;
                    end
                    if (acc) exp_q.push_back(model(va[31:16], va[15:0], vb[31:16], vb[15:0], va[3] ^ vb[7]));
                    else check("accept timeout", 1'b0, 1'b1);
                end
                in_valid = 1'b0;
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                out_ready = 1'b0;
                @(posedge clk);
                #1;
                check("stall in_ready", in_ready, 1'b0);
                check("stall out_valid", out_valid, 1'b1);
                repeat (4) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        for (int t = 0; t < 40 && exp_q.size() != 0; t++) @(posedge clk);
        @(posedge clk);
        #1;
        check("drain empty", exp_q.size(), 0);
        check("beats out", got_cnt, 8);
        check("ovf sticky", ovf, OVF_FLAG);
        mon_en = 1'b0;

        // Reset with three beats in flight.
        @(posedge clk);
        #1;
        a_re = 16'h4000; a_im = 16'h1000; b_re = 16'h4000; b_im = 16'h2000; conj = 1'b0;
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("pre-reset valid", out_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid rst out_valid", out_valid, 1'b0);
        check("mid rst ovf", ovf, 1'b0);
        check("mid rst m_re", m_re, 16'h0000);
        #3;
        rst_n = 1'b1;
        stale = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        check("no stale beat", stale, 0);
        check("post rst in_ready", in_ready, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
